// File: rtl/lag_pkg.sv
// Shared sizing constants and controller state encoding for the lag accumulator.
package lag_pkg;

    localparam int LAG_N  = 512;
    localparam int ACC_W  = 32;
    localparam int ADDR_W = $clog2(LAG_N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_CLEAR,
        S_DUMP
    } state_t;

endpackage

// File: rtl/lag_accumulator_if.sv
// Sample, control and dump-stream signals of the lag accumulator.
interface lag_accumulator_if #(
    parameter int ACC_W = lag_pkg::ACC_W
);
    logic             clr;
    logic [7:0]       din;
    logic             sin;
    logic [7:0]       dshift;
    logic             dvalid;
    logic             dump;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_last;
    logic             busy;
    logic [15:0]      nsamp;
    logic             ovf;
    logic             drop;

    modport master (
        output clr, din, sin, dshift, dvalid, dump,
        input  acc_out, acc_valid, acc_last, busy, nsamp, ovf, drop
    );

    modport slave (
        input  clr, din, sin, dshift, dvalid, dump,
        output acc_out, acc_valid, acc_last, busy, nsamp, ovf, drop
    );
endinterface

// File: rtl/acc_ram.sv
// Simple dual-port accumulator store: one write port, one registered read port.
module acc_ram #(
    parameter int DEPTH = lag_pkg::LAG_N,
    parameter int WIDTH = lag_pkg::ACC_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: neither the array nor the read register is reset, so the tools can map them onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/lag_accumulator.sv
// Per-lag correlation accumulator: acc[k] += ref * dshift for the k-th word of each burst.
module lag_accumulator #(
    parameter int LAG_N = lag_pkg::LAG_N,
    parameter int ACC_W = lag_pkg::ACC_W
) (
    input logic              clk,
    input logic              rst_n,
    lag_accumulator_if.slave bus
);
    localparam int                ADDR_W   = $clog2(LAG_N);
    localparam logic [ADDR_W-1:0] LAST_LAG = ADDR_W'(LAG_N - 1);

    lag_pkg::state_t r_state, w_state_nxt;

    logic [7:0]        r_ref;
    logic [ADDR_W-1:0] r_lag;
    logic              r_lag_full;
    logic [15:0]       r_nsamp;
    logic              r_ovf, r_drop;

    logic              r_s1_valid, r_s2_valid;
    logic [ADDR_W-1:0] r_s1_addr, r_s2_addr;
    logic [7:0]        r_s1_ref, r_s1_dat;
    logic [15:0]       r_s2_prod;
    logic              r_fwd_hit;
    logic [ACC_W-1:0]  r_fwd_data;

    logic [ADDR_W-1:0] r_cnt;
    logic              r_cnt_done;
    logic              r_rd_valid, r_rd_last;
    logic [ACC_W-1:0]  r_acc_out;
    logic              r_acc_valid, r_acc_last;

    logic              w_idle_or_acc, w_take_dump, w_take_sin, w_take_word;
    logic              w_pipe_busy, w_step, w_carry, w_ram_we;
    logic [ADDR_W-1:0] w_ram_waddr, w_ram_raddr;
    logic [ACC_W-1:0]  w_ram_wdata, w_ram_rdata, w_old, w_sum_raw, w_sum;

    // A dvalid coinciding with sin still belongs to the burst being closed.
    always_comb begin
        w_idle_or_acc = (r_state == lag_pkg::S_IDLE) || (r_state == lag_pkg::S_ACC);
        w_take_dump   = !bus.clr && bus.dump && w_idle_or_acc;
        w_take_sin    = !bus.clr && !bus.dump && bus.sin && w_idle_or_acc;
        w_take_word   = (r_state == lag_pkg::S_ACC) && bus.dvalid && !r_lag_full;
        w_pipe_busy   = r_s1_valid || r_s2_valid;
        w_step        = ((r_state == lag_pkg::S_CLEAR) || (r_state == lag_pkg::S_DUMP))
                        && !w_pipe_busy && !r_cnt_done;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_old                = r_fwd_hit ? r_fwd_data : w_ram_rdata;
        {w_carry, w_sum_raw} = {1'b0, w_old} + {1'b0, ACC_W'(r_s2_prod)};
        w_sum                = w_carry ? '1 : w_sum_raw;
        w_ram_we             = r_s2_valid || ((r_state == lag_pkg::S_CLEAR) && w_step);
        w_ram_waddr          = r_s2_valid ? r_s2_addr : r_cnt;
        w_ram_wdata          = r_s2_valid ? w_sum : '0;
        w_ram_raddr          = w_step ? r_cnt : r_s1_addr;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.clr) begin
            w_state_nxt = lag_pkg::S_CLEAR;
        end else begin
            case (r_state)
                lag_pkg::S_IDLE, lag_pkg::S_ACC: begin
                    if (bus.dump)     w_state_nxt = lag_pkg::S_DUMP;
                    else if (bus.sin) w_state_nxt = lag_pkg::S_ACC;
                end
                lag_pkg::S_CLEAR: if (w_step && (r_cnt == LAST_LAG)) w_state_nxt = lag_pkg::S_IDLE;
                lag_pkg::S_DUMP:  if (r_acc_last) w_state_nxt = lag_pkg::S_IDLE;
                default:          w_state_nxt = lag_pkg::S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= lag_pkg::S_IDLE;
            r_ref      <= '0;
            r_lag      <= '0;
            r_lag_full <= 1'b0;
            r_nsamp    <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take_sin) begin
                r_ref      <= bus.din;
                r_lag      <= '0;
                r_lag_full <= 1'b0;
            end else if (w_take_word) begin
                if (r_lag == LAST_LAG) r_lag_full <= 1'b1;
                else                   r_lag      <= r_lag + ADDR_W'(1);
            end
            if (bus.clr)                              r_nsamp <= '0;
            else if (w_take_sin && (r_nsamp != '1))   r_nsamp <= r_nsamp + 16'd1;
            if (bus.clr)                                           r_drop <= 1'b0;
            else if (!w_idle_or_acc && (bus.sin || bus.dvalid))    r_drop <= 1'b1;
        end
    end

    // Adjacent words to the same lag (one-word bursts) bypass the RAM read via r_fwd_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_ref   <= '0;
            r_s1_dat   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_prod  <= '0;
            r_fwd_hit  <= 1'b0;
            r_fwd_data <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_s1_valid <= w_take_word;
            r_s1_addr  <= r_lag;
            r_s1_ref   <= r_ref;
            r_s1_dat   <= bus.dshift;
            r_s2_valid <= r_s1_valid;
            r_s2_addr  <= r_s1_addr;
            r_s2_prod  <= 16'(r_s1_ref) * 16'(r_s1_dat);
            r_fwd_hit  <= r_s1_valid && r_s2_valid && (r_s1_addr == r_s2_addr);
            r_fwd_data <= w_sum;
            if ((r_state == lag_pkg::S_CLEAR) && w_step) r_ovf <= 1'b0;
            else if (r_s2_valid && w_carry)              r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_cnt_done  <= 1'b1;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_acc_out   <= '0;
            r_acc_valid <= 1'b0;
            r_acc_last  <= 1'b0;
        end else begin
            if (bus.clr || w_take_dump) begin
                r_cnt      <= '0;
                r_cnt_done <= 1'b0;
            end else if (w_step) begin
                if (r_cnt == LAST_LAG) r_cnt_done <= 1'b1;
                else                   r_cnt      <= r_cnt + ADDR_W'(1);
            end
            r_rd_valid  <= w_step && (r_state == lag_pkg::S_DUMP) && !bus.clr;
            r_rd_last   <= w_step && (r_state == lag_pkg::S_DUMP) && !bus.clr && (r_cnt == LAST_LAG);
            r_acc_valid <= r_rd_valid && !bus.clr;
            r_acc_last  <= r_rd_last && !bus.clr;
            r_acc_out   <= (r_rd_valid && !bus.clr) ? w_ram_rdata : '0;
        end
    end

    acc_ram #(.DEPTH(LAG_N), .WIDTH(ACC_W), .AW(ADDR_W)) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    assign bus.acc_out   = r_acc_out;
    assign bus.acc_valid = r_acc_valid;
    assign bus.acc_last  = r_acc_last;
    assign bus.busy      = (r_state == lag_pkg::S_CLEAR) || (r_state == lag_pkg::S_DUMP) || w_pipe_busy;
    assign bus.nsamp     = r_nsamp;
    assign bus.ovf       = r_ovf;
    assign bus.drop      = r_drop;
endmodule

// File: tb/tb_lag_accumulator.sv
// Directed bench for lag_accumulator: bursts, saturation, overrun, dump abort and reset.
module tb_lag_accumulator;
    import lag_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lag_accumulator_if #(.ACC_W(ACC_W)) bus ();

    lag_accumulator #(.LAG_N(LAG_N), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_acc [LAG_N];
    logic [31:0] got     [LAG_N];
    int          got_n, last_idx, first_cyc, last_cyc;

    task automatic drive(input logic c, input logic s, input logic v, input logic d,
                         input logic [7:0] di, input logic [7:0] ds);
        @(negedge clk);
        bus.clr = c; bus.sin = s; bus.dvalid = v; bus.dump = d; bus.din = di; bus.dshift = ds;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        drive(0, 0, 0, 0, 8'd0, 8'd0);
        while (bus.busy && k < 4000) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle_timeout busy=%b required 0", tag, bus.busy);
        end
    endtask

    task automatic do_clear(input string tag);
        drive(1, 0, 0, 0, 8'd0, 8'd0);
        wait_idle(tag);
        foreach (exp_acc[i]) exp_acc[i] = '0;
    endtask

    task automatic run_dump(input string tag);
        int cyc_i = 0;
        bit seen_last = 1'b0;
        got_n = 0; last_idx = -1; first_cyc = -1; last_cyc = -1;
        foreach (got[i]) got[i] = 'x;
        drive(0, 0, 0, 1, 8'd0, 8'd0);
        drive(0, 0, 0, 0, 8'd0, 8'd0);
        while (!seen_last && cyc_i < 3000) begin
            if (bus.acc_valid) begin
                if (first_cyc < 0) first_cyc = cyc_i;
                last_cyc = cyc_i;
                if (got_n < LAG_N) got[got_n] = bus.acc_out;
                if (bus.acc_last) begin
                    last_idx  = got_n;
                    seen_last = 1'b1;
                end
                got_n++;
            end
            @(negedge clk);
            cyc_i++;
        end
        n_vec++;
        if (!seen_last) begin
            n_err++;
            $display("FAIL %s dump_timeout acc_last seen=%b required 1", tag, seen_last);
        end
        wait_idle(tag);
    endtask

    task automatic test_reset();
        bus.clr = 0; bus.sin = 0; bus.dvalid = 0; bus.dump = 0; bus.din = 0; bus.dshift = 0;
        repeat (3) @(negedge clk);
        n_vec += 7;
        if (bus.acc_out   !== '0)    begin n_err++; $display("FAIL rst_acc_out got %h want 0", bus.acc_out); end
        if (bus.acc_valid !== 1'b0)  begin n_err++; $display("FAIL rst_acc_valid got %b want 0", bus.acc_valid); end
        if (bus.acc_last  !== 1'b0)  begin n_err++; $display("FAIL rst_acc_last got %b want 0", bus.acc_last); end
        if (bus.busy      !== 1'b0)  begin n_err++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        if (bus.nsamp     !== 16'd0) begin n_err++; $display("FAIL rst_nsamp got %0d want 0", bus.nsamp); end
        if (bus.ovf       !== 1'b0)  begin n_err++; $display("FAIL rst_ovf got %b want 0", bus.ovf); end
        if (bus.drop      !== 1'b0)  begin n_err++; $display("FAIL rst_drop got %b want 0", bus.drop); end
        rst_n = 1'b1;
        do_clear("reset_clr");
    endtask

    task automatic test_basic();
        drive(0, 1, 0, 0, 8'd3, 8'd0);
        for (int k = 1; k <= 4; k++) drive(0, 0, 1, 0, 8'd0, 8'(k));
        exp_acc[0] = 32'd3; exp_acc[1] = 32'd6; exp_acc[2] = 32'd9; exp_acc[3] = 32'd12;
        run_dump("basic");
        n_vec += 4;
        if (got_n !== LAG_N)      begin n_err++; $display("FAIL basic_count got %0d want %0d", got_n, LAG_N); end
        if (last_idx !== LAG_N-1) begin n_err++; $display("FAIL basic_last got %0d want %0d", last_idx, LAG_N-1); end
        if (last_cyc - first_cyc + 1 !== got_n) begin n_err++; $display("FAIL basic_gap span %0d want %0d", last_cyc - first_cyc + 1, got_n); end
        if (bus.nsamp !== 16'd1)  begin n_err++; $display("FAIL basic_nsamp got %0d want 1", bus.nsamp); end
        for (int i = 0; i < LAG_N; i++) begin
            n_vec++;
            if (got[i] !== exp_acc[i]) begin n_err++; $display("FAIL basic_acc[%0d] got %h want %h", i, got[i], exp_acc[i]); end
        end
    endtask

    task automatic test_two_bursts();
        do_clear("bursts_clr");
        drive(0, 0, 1, 0, 8'd0, 8'd100);
        drive(0, 1, 0, 0, 8'd2, 8'd0);
        drive(0, 0, 1, 0, 8'd0, 8'd10);
        drive(0, 0, 1, 0, 8'd0, 8'd10);
        drive(0, 1, 0, 0, 8'd5, 8'd0);
        drive(0, 0, 1, 0, 8'd0, 8'd10);
        drive(0, 0, 1, 0, 8'd0, 8'd10);
        exp_acc[0] = 32'd70; exp_acc[1] = 32'd70;
        run_dump("bursts");
        n_vec += 3;
        if (got_n !== LAG_N)     begin n_err++; $display("FAIL bursts_count got %0d want %0d", got_n, LAG_N); end
        if (bus.nsamp !== 16'd2) begin n_err++; $display("FAIL bursts_nsamp got %0d want 2", bus.nsamp); end
        if (bus.drop !== 1'b0)   begin n_err++; $display("FAIL bursts_drop got %b want 0", bus.drop); end
        for (int i = 0; i < LAG_N; i++) begin
            n_vec++;
            if (got[i] !== exp_acc[i]) begin n_err++; $display("FAIL bursts_acc[%0d] got %h want %h", i, got[i], exp_acc[i]); end
        end
    endtask

    task automatic test_overrun();
        do_clear("overrun_clr");
        drive(0, 1, 0, 0, 8'd1, 8'd0);
        repeat (600) drive(0, 0, 1, 0, 8'd0, 8'd1);
        wait_idle("overrun_drain");
        foreach (exp_acc[i]) exp_acc[i] = 32'd1;
        n_vec++;
        if (bus.drop !== 1'b0) begin n_err++; $display("FAIL overrun_drop got %b want 0", bus.drop); end
        run_dump("overrun");
        n_vec += 3;
        if (got_n !== LAG_N)      begin n_err++; $display("FAIL overrun_count got %0d want %0d", got_n, LAG_N); end
        if (last_idx !== LAG_N-1) begin n_err++; $display("FAIL overrun_last got %0d want %0d", last_idx, LAG_N-1); end
        if (last_cyc - first_cyc + 1 !== got_n) begin n_err++; $display("FAIL overrun_gap span %0d want %0d", last_cyc - first_cyc + 1, got_n); end
        for (int i = 0; i < LAG_N; i++) begin
            n_vec++;
            if (got[i] !== exp_acc[i]) begin n_err++; $display("FAIL overrun_acc[%0d] got %h want %h", i, got[i], exp_acc[i]); end
        end
    endtask

    task automatic test_dump_abort();
        int k = 0;
        drive(0, 0, 0, 1, 8'd0, 8'd0);
        drive(0, 0, 0, 0, 8'd0, 8'd0);
        while (!bus.acc_valid && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (bus.acc_valid !== 1'b1) begin n_err++; $display("FAIL abort_stream_start got %b want 1", bus.acc_valid); end
        drive(0, 1, 0, 0, 8'd9, 8'd0);
        drive(1, 0, 0, 0, 8'd0, 8'd0);
        n_vec += 2;
        if (bus.drop !== 1'b1)   begin n_err++; $display("FAIL abort_drop got %b want 1", bus.drop); end
        if (bus.nsamp !== 16'd1) begin n_err++; $display("FAIL abort_nsamp got %0d want 1", bus.nsamp); end
        drive(0, 0, 0, 0, 8'd0, 8'd0);
        n_vec += 2;
        if (bus.acc_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid_off got %b want 0", bus.acc_valid); end
        if (bus.busy !== 1'b1)      begin n_err++; $display("FAIL abort_busy got %b want 1", bus.busy); end
        wait_idle("abort_clear");
        foreach (exp_acc[i]) exp_acc[i] = '0;
        n_vec += 2;
        if (bus.drop !== 1'b0)   begin n_err++; $display("FAIL abort_drop_clr got %b want 0", bus.drop); end
        if (bus.nsamp !== 16'd0) begin n_err++; $display("FAIL abort_nsamp_clr got %0d want 0", bus.nsamp); end
        run_dump("abort");
        n_vec++;
        if (got_n !== LAG_N) begin n_err++; $display("FAIL abort_count got %0d want %0d", got_n, LAG_N); end
        for (int i = 0; i < LAG_N; i++) begin
            n_vec++;
            if (got[i] !== exp_acc[i]) begin n_err++; $display("FAIL abort_acc[%0d] got %h want %h", i, got[i], exp_acc[i]); end
        end
    endtask

    // 66051 * 255*255 + 255*3 = 0xFFFFFF00, one word per cycle into lag 0.
    task automatic test_saturate();
        do_clear("sat_clr");
        drive(0, 1, 0, 0, 8'd255, 8'd0);
        repeat (66051) drive(0, 1, 1, 0, 8'd255, 8'd255);
        drive(0, 0, 1, 0, 8'd255, 8'd3);
        wait_idle("sat_drain");
        n_vec += 2;
        if (bus.ovf !== 1'b0)        begin n_err++; $display("FAIL sat_pre_ovf got %b want 0", bus.ovf); end
        if (bus.nsamp !== 16'hFFFF)  begin n_err++; $display("FAIL sat_nsamp got %0d want 65535", bus.nsamp); end
        exp_acc[0] = 32'hFFFF_FF00;
        run_dump("sat_pre");
        for (int i = 0; i < LAG_N; i++) begin
            n_vec++;
            if (got[i] !== exp_acc[i]) begin n_err++; $display("FAIL sat_pre_acc[%0d] got %h want %h", i, got[i], exp_acc[i]); end
        end
        drive(0, 1, 0, 0, 8'd255, 8'd0);
        drive(0, 0, 1, 0, 8'd0, 8'd255);
        wait_idle("sat_add");
        n_vec++;
        if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL sat_ovf got %b want 1", bus.ovf); end
        exp_acc[0] = 32'hFFFF_FFFF;
        run_dump("sat_post");
        n_vec += 2;
        if (got[0] !== exp_acc[0])  begin n_err++; $display("FAIL sat_acc0 got %h want %h", got[0], exp_acc[0]); end
        if (got[1] !== 32'd0)       begin n_err++; $display("FAIL sat_acc1 got %h want 0", got[1]); end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 0, 0, 8'd7, 8'd0);
        drive(0, 0, 1, 0, 8'd0, 8'd1);
        drive(0, 0, 1, 0, 8'd0, 8'd2);
        drive(0, 0, 0, 0, 8'd0, 8'd0);
        n_vec += 2;
        if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_pre got %b want 1", bus.busy); end
        if (bus.ovf !== 1'b1)  begin n_err++; $display("FAIL mid_ovf_pre got %b want 1", bus.ovf); end
        #2 rst_n = 1'b0;
        #1;
        n_vec += 5;
        if (bus.busy !== 1'b0)      begin n_err++; $display("FAIL mid_busy got %b want 0", bus.busy); end
        if (bus.nsamp !== 16'd0)    begin n_err++; $display("FAIL mid_nsamp got %0d want 0", bus.nsamp); end
        if (bus.ovf !== 1'b0)       begin n_err++; $display("FAIL mid_ovf got %b want 0", bus.ovf); end
        if (bus.acc_valid !== 1'b0) begin n_err++; $display("FAIL mid_acc_valid got %b want 0", bus.acc_valid); end
        if (bus.acc_out !== '0)     begin n_err++; $display("FAIL mid_acc_out got %h want 0", bus.acc_out); end
        @(negedge clk);
        rst_n = 1'b1;
        do_clear("mid_clr");
        drive(0, 1, 0, 0, 8'd4, 8'd0);
        drive(0, 0, 1, 0, 8'd0, 8'd5);
        drive(0, 0, 1, 0, 8'd0, 8'd6);
        exp_acc[0] = 32'd20; exp_acc[1] = 32'd24;
        run_dump("mid");
        for (int i = 0; i < LAG_N; i++) begin
            n_vec++;
            if (got[i] !== exp_acc[i]) begin n_err++; $display("FAIL mid_acc[%0d] got %h want %h", i, got[i], exp_acc[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_bursts();
        test_overrun();
        test_dump_abort();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lag_accumulator.md
LAG_ACCUMULATOR -- requirements
Module: lag_accumulator

Interface
REQ-001 SHALL have parameter LAG_N, default 512, number of lag bins (power of two).
REQ-002 SHALL have parameter ACC_W, default 32, accumulator width in bits.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port clr  in  1  one-cycle pulse; zero all accumulators and nsamp.
REQ-006 SHALL have port din  in  8  current (reference) sample; latched on sin.
REQ-007 SHALL have port sin  in  1  burst-start strobe; one cycle, precedes first dvalid.
REQ-008 SHALL have port dshift  in  8  delayed history word of the burst.
REQ-009 SHALL have port dvalid  in  1  dshift qualifier; k-th dvalid after sin is lag k.
REQ-010 SHALL have port dump  in  1  one-cycle pulse; stream all accumulators out.
REQ-011 SHALL have port acc_out  out  ACC_W  accumulator value during dump.
REQ-012 SHALL have port acc_valid  out  1  acc_out qualifier.
REQ-013 SHALL have port acc_last  out  1  high with lag LAG_N-1 word.
REQ-014 SHALL have port busy  out  1  high in CLEAR or DUMP, or while the accumulate pipeline is non-empty.
REQ-015 SHALL have port nsamp  out  16  count of accepted bursts, saturating at 65535.
REQ-016 SHALL have port ovf  out  1  sticky; any accumulator saturated.
REQ-017 SHALL have port drop  out  1  sticky; sin or dvalid ignored because not in IDLE/ACC.

Function
REQ-018 SHALL implement states IDLE, ACC, CLEAR, DUMP.
REQ-019 Priority when simultaneous SHALL be clr > dump > sin.
REQ-020 IDLE/ACC + sin SHALL: latch din as ref, reset lag counter to 0, increment nsamp, enter ACC.
REQ-021 ACC + dvalid SHALL: acc[lag] <= acc[lag] + ref*dshift (unsigned 8x8=16-bit product, zero-extended), then increment lag.
REQ-022 Accumulate pipeline SHALL be 3 stages (address, RAM read + multiply, add + write); one word accepted per cycle, no backpressure.
REQ-023 Lag counter SHALL saturate at LAG_N-1; dvalid beyond LAG_N words SHALL be ignored and SHALL NOT set drop.
REQ-024 A new sin in ACC SHALL restart the lag counter at 0; words already in the pipeline SHALL complete.
REQ-025 Addition SHALL saturate at 2^ACC_W-1 and set ovf.
REQ-026 dvalid in IDLE (no preceding sin) SHALL be ignored.
REQ-027 CLEAR SHALL write 0 to addresses 0..LAG_N-1 in LAG_N consecutive cycles after the pipeline drains, clear nsamp and ovf, then return to IDLE.
REQ-028 DUMP SHALL wait for the pipeline to drain, read addresses 0..LAG_N-1 consecutively, and assert acc_valid for LAG_N consecutive cycles starting 2 cycles after the first read; acc_last SHALL be high on the final word; then return to IDLE.
REQ-029 sin, dvalid or dump arriving in CLEAR/DUMP SHALL be ignored; sin/dvalid SHALL set drop; drop SHALL be cleared only by clr or reset.
REQ-030 clr in DUMP SHALL abort the stream, deassert acc_valid next cycle, and enter CLEAR.

Reset
REQ-031 rst_n low SHALL force state IDLE, lag counter 0, ref 0, nsamp 0, ovf 0, drop 0, acc_out 0, acc_valid 0, acc_last 0, busy 0, and flush the pipeline.
REQ-032 RAM contents SHALL NOT be reset; they initialise to 0 at configuration, and clr is required after a mid-operation reset.

Structure
REQ-033 Package lag_pkg SHALL hold LAG_N, ACC_W, ADDR_W=log2(LAG_N), and the state encoding.
REQ-034 Accumulator storage SHALL be sub-module acc_ram (simple dual-port, 1-cycle registered read, LAG_N x ACC_W, block-RAM inferred).

Verification
REQ-035 Reset, sin din=3, 4 dvalid dshift=1,2,3,4, dump -> acc_out 3,6,9,12 then 0 for lags 4..511; nsamp=1.
REQ-036 Two bursts din=2 then din=5, each with dshift=10 on lags 0..1 -> dump yields acc[0]=acc[1]=70; nsamp=2.
REQ-037 Preload acc[0]=0xFFFFFF00 via bursts, then add 255*255 -> acc[0]=0xFFFFFFFF, ovf=1.
REQ-038 600 dvalid after one sin, din=1, dshift=1 -> acc[0..511]=1, drop=0; dump gives exactly 512 acc_valid cycles, acc_last on the 512th.
REQ-039 sin during DUMP -> ignored, drop=1, nsamp unchanged; clr mid-dump -> acc_valid low next cycle, then all zeros on the next dump.
REQ-040 rst_n low mid-burst -> all outputs at reset values on the same cycle; a following burst starts at lag 0.
